// File: rtl/aha_pwr_gate_seq_if.sv
// Bundle of sleep/debug/WIC handshakes and gate-control vectors for aha_pwr_gate_seq.
// master drives the controller inputs; slave is the sequencer side.
interface aha_pwr_gate_seq_if #(
   parameter int unsigned NUM_CH = 13
);
   logic              DBGPWRUPREQ;
   logic              DBGSYSPWRUPREQ;
   logic              SLEEP;
   logic              SLEEPDEEP;
   logic              PMU_WAKEUP;
   logic              PMU_WIC_EN_ACK;
   logic [NUM_CH-1:0] GATE_EN_in;
   logic [NUM_CH-1:0] GATE_EN_out;
   logic              DBGPWRUPACK;
   logic              DBGSYSPWRUPACK;
   logic              PMU_WIC_EN_REQ;
   logic              SLEEPHOLDREQn;
   logic              ALL_GATED;

   modport master (
      output DBGPWRUPREQ, DBGSYSPWRUPREQ, SLEEP, SLEEPDEEP, PMU_WAKEUP, PMU_WIC_EN_ACK,
             GATE_EN_in,
      input  GATE_EN_out, DBGPWRUPACK, DBGSYSPWRUPACK, PMU_WIC_EN_REQ, SLEEPHOLDREQn,
             ALL_GATED
   );

   modport slave (
      input  DBGPWRUPREQ, DBGSYSPWRUPREQ, SLEEP, SLEEPDEEP, PMU_WAKEUP, PMU_WIC_EN_ACK,
             GATE_EN_in,
      output GATE_EN_out, DBGPWRUPACK, DBGSYSPWRUPACK, PMU_WIC_EN_REQ, SLEEPHOLDREQn,
             ALL_GATED
   );
endinterface

// File: rtl/aha_pwr_gate_seq.sv
// Clock-gate sequencer: per-channel sleep policy masks, gating hysteresis,
// debug power-up req/ack handshake and WIC enable FSM.
module aha_pwr_gate_seq #(
   parameter int unsigned      NUM_CH      = 13,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter int unsigned      GATE_DLY    = 4,
   parameter logic [NUM_CH-1:0] SLEEP_MASK = '0,
   parameter logic [NUM_CH-1:0] DEEP_MASK  = NUM_CH'(12'hFFF),
   parameter logic [NUM_CH-1:0] DBG_MASK   = '0,
   parameter logic [NUM_CH-1:0] WIC_MASK   = '0
) (
   input logic              CLK,
   input logic              RESETn,
   aha_pwr_gate_seq_if.slave bus
);

   localparam int unsigned     CntW   = (GATE_DLY > 0) ? $clog2(GATE_DLY + 1) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(GATE_DLY);

   typedef enum logic [1:0] {StOff, StReq, StOn} wic_state_e;

   wic_state_e              wic_q, wic_d;
   logic [SYNC_STAGES-1:0]  dreq_sync, sreq_sync;
   logic                    dreq, sreq, dbg, wic_ok;
   logic [NUM_CH-1:0]       block, cond, gate_d, gate_q;
   logic [CntW-1:0]         cnt_d [NUM_CH];
   logic [CntW-1:0]         cnt_q [NUM_CH];
   logic                    dack_d, dack_q, sack_d, sack_q, all_gated_q;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         dreq_sync <= '0;
         sreq_sync <= '0;
      end else begin
         dreq_sync <= {dreq_sync[SYNC_STAGES-2:0], bus.DBGPWRUPREQ};
         sreq_sync <= {sreq_sync[SYNC_STAGES-2:0], bus.DBGSYSPWRUPREQ};
      end
   end

   assign dreq   = dreq_sync[SYNC_STAGES-1];
   assign sreq   = sreq_sync[SYNC_STAGES-1];
   assign dbg    = dreq | sreq;
   assign wic_ok = (wic_q == StOn) & bus.PMU_WIC_EN_ACK & ~bus.PMU_WAKEUP;

   // Blocking wins over any gate request, so a debug request mid-countdown restarts it.
   assign block = (DBG_MASK & {NUM_CH{dbg}}) | (WIC_MASK & {NUM_CH{~wic_ok}});
   assign cond  = (bus.GATE_EN_in | (SLEEP_MASK & {NUM_CH{bus.SLEEP}}) |
                   (DEEP_MASK & {NUM_CH{bus.SLEEPDEEP}})) & ~block;

   always_comb begin
      wic_d = wic_q;
      unique case (wic_q)
         StOff:   wic_d = StReq;
         StReq:   if (bus.PMU_WIC_EN_ACK) wic_d = StOn;
         StOn:    if (!bus.PMU_WIC_EN_ACK) wic_d = StReq;
         default: wic_d = StOff;
      endcase
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]  = cnt_q[i];
         gate_d[i] = gate_q[i];
         if (!cond[i]) begin
            cnt_d[i]  = '0;
            gate_d[i] = 1'b0;
         end else if (cnt_q[i] != CntMax) begin
            cnt_d[i]  = cnt_q[i] + 1'b1;
            gate_d[i] = 1'b0;
         end else begin
            gate_d[i] = 1'b1;
         end
      end
   end

   // Acks rise only once debug-critical clocks are running; never drop while req held.
   always_comb begin
      dack_d = dack_q;
      sack_d = sack_q;
      if (!dreq) dack_d = 1'b0;
      else if (~|(gate_q & DBG_MASK)) dack_d = 1'b1;
      if (!sreq) sack_d = 1'b0;
      else if (~|(gate_q & DBG_MASK)) sack_d = 1'b1;
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         wic_q       <= StOff;
         gate_q      <= '0;
         dack_q      <= 1'b0;
         sack_q      <= 1'b0;
         all_gated_q <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      end else begin
         wic_q       <= wic_d;
         gate_q      <= gate_d;
         dack_q      <= dack_d;
         sack_q      <= sack_d;
         all_gated_q <= &gate_d;
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign bus.GATE_EN_out    = gate_q;
   assign bus.DBGPWRUPACK    = dack_q;
   assign bus.DBGSYSPWRUPACK = sack_q;
   assign bus.PMU_WIC_EN_REQ = (wic_q != StOff);
   assign bus.SLEEPHOLDREQn  = 1'b1;
   assign bus.ALL_GATED      = all_gated_q;

endmodule
